// File: rtl/demux_dispatch_ctrl.sv
// Dispatch controller for the 1-to-4 demultiplexer datapath.
// Accepts one word at a time from an upstream valid/ready source, chooses a
// destination channel (round-robin over enabled channels, or a fixed channel),
// drives the demux select lines and holds the word until the chosen channel
// accepts it, or until it is dropped because the channel was disabled or the
// wait exceeded TIMEOUT cycles.
module demux_dispatch_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              cfg_mode,
  input  logic [1:0]        cfg_fixed_sel,
  input  logic [3:0]        cfg_en,
  output logic [1:0]        sel,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [3:0]        out_ready,
  output logic [CNT_W-1:0]  sent_cnt,
  output logic              drop_pulse
);

  // The wait counter only needs to reach TIMEOUT-1: the drop is decided in
  // the SEND cycle where one more stalled cycle would hit TIMEOUT.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                drop_q, drop_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic                target_avail;
  logic [1:0]          target;
  logic                timeout_hit;

  // First enabled channel at or above ptr, wrapping 3 -> 0.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] en);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && en[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Destination selection and availability for the word offered in IDLE.
  always_comb begin
    target_avail = 1'b0;
    target       = 2'd0;
    if (cfg_mode) begin
      target_avail = cfg_en[cfg_fixed_sel];
      target       = cfg_fixed_sel;
    end else begin
      target_avail = |cfg_en;
      target       = rr_pick(rr_ptr_q, cfg_en);
    end
  end

  // Timeout only applies when TIMEOUT is non-zero.
  always_comb begin
    timeout_hit = (TIMEOUT > 0) && (wait_q == WAIT_LAST);
  end

  // Next-state logic and handshake outputs; delivery has priority over drop.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_ptr_d  = rr_ptr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    drop_d    = 1'b0;
    wait_d    = wait_q;
    in_ready  = 1'b0;
    out_valid = 4'b0000;

    case (state_q)
      IDLE: begin
        // in_ready must read low while reset is held, even though the state
        // register already sits in IDLE.
        in_ready = rst_n & target_avail;
        wait_d   = '0;
        if (in_valid && in_ready) begin
          data_d  = in_data;
          sel_d   = target;
          state_d = SEND;
        end
      end

      SEND: begin
        out_valid = 4'b0001 << sel_q;
        if (out_ready[sel_q]) begin
          cnt_d    = cnt_q + CNT_W'(1);
          rr_ptr_d = sel_q + 2'd1;
          wait_d   = '0;
          state_d  = IDLE;
        end else if (!cfg_en[sel_q] || timeout_hit) begin
          drop_d   = 1'b1;
          rr_ptr_d = sel_q + 2'd1;
          wait_d   = '0;
          state_d  = IDLE;
        end else begin
          wait_d   = wait_q + WAIT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      rr_ptr_q <= 2'd0;
      data_q   <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      wait_q   <= wait_d;
    end
  end

  assign sel        = sel_q;
  assign out_data   = data_q;
  assign sent_cnt   = cnt_q;
  assign drop_pulse = drop_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl: directed scenarios with literal
// expectations followed by randomized traffic checked every cycle against a
// transaction-level reference model.
module tb_demux_dispatch_ctrl;

  localparam int DATA_W  = 8;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              cfg_mode = 1'b0;
  logic [1:0]        cfg_fixed_sel = 2'd0;
  logic [3:0]        cfg_en = 4'hF;
  logic [1:0]        sel;
  logic [3:0]        out_valid;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_ready = 4'h0;
  logic [CNT_W-1:0]  sent_cnt;
  logic              drop_pulse;

  demux_dispatch_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cfg_mode(cfg_mode), .cfg_fixed_sel(cfg_fixed_sel),
    .cfg_en(cfg_en), .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .sent_cnt(sent_cnt), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one held transaction at a time.
  bit              m_busy   = 0;
  logic [1:0]      m_ch     = 2'd0;
  logic [1:0]      m_ptr    = 2'd0;
  logic [DATA_W-1:0] m_data = '0;
  int              m_waited = 0;
  logic [CNT_W-1:0] m_sent  = '0;
  bit              m_drop   = 0;

  function automatic bit exp_ready();
    if (!rst_n || m_busy) return 0;
    if (cfg_mode) return cfg_en[cfg_fixed_sel];
    return (cfg_en != 4'h0);
  endfunction

  function automatic logic [1:0] pick_channel();
    if (cfg_mode) return cfg_fixed_sel;
    for (int k = 0; k < 4; k++)
      if (cfg_en[(int'(m_ptr) + k) % 4]) return 2'((int'(m_ptr) + k) % 4);
    return m_ptr;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_ch = 2'd0; m_ptr = 2'd0; m_data = '0;
      m_waited = 0; m_sent = '0; m_drop = 0;
    end else begin
      m_drop = 0;
      if (!m_busy) begin
        if (in_valid && exp_ready()) begin
          m_ch = pick_channel();
          m_data = in_data;
          m_busy = 1;
          m_waited = 0;
        end
      end else if (out_ready[m_ch]) begin
        m_sent = m_sent + 1'b1;
        m_ptr = m_ch + 2'd1;
        m_busy = 0;
      end else if (!cfg_en[m_ch] || (TIMEOUT > 0 && m_waited + 1 >= TIMEOUT)) begin
        m_drop = 1;
        m_ptr = m_ch + 2'd1;
        m_busy = 0;
      end else begin
        m_waited++;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(exp_ready()));
    chk("out_valid", 32'(out_valid), m_busy ? 32'(4'b0001 << m_ch) : 32'd0);
    if (m_busy) begin
      chk("sel", 32'(sel), 32'(m_ch));
      chk("out_data", 32'(out_data), 32'(m_data));
    end
    chk("sent_cnt", 32'(sent_cnt), 32'(m_sent));
    chk("drop_pulse", 32'(drop_pulse), 32'(m_drop));
  end

  // Observation log for the directed scenarios.
  logic [1:0] del_q[$];
  int ov_cnt = 0;
  int drop_cnt = 0;
  always @(negedge clk) begin
    if ((out_valid & out_ready) != 4'h0) del_q.push_back(sel);
    if (out_valid != 4'h0) ov_cnt++;
    if (drop_pulse) drop_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d);
    bit acc;
    acc = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("accept", 32'(acc), 32'd1);
  endtask

  task automatic chk_seq(input string nm, input logic [1:0] exp[]);
    chk({nm, "_len"}, 32'(del_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < del_q.size(); i++)
      chk(nm, 32'(del_q[i]), 32'(exp[i]));
  endtask

  int p;
  bit seen;

  initial begin
    rst_n = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_sent", 32'(sent_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(1);

    // Round-robin over all channels.
    cfg_mode = 0; cfg_en = 4'hF; out_ready = 4'hF;
    del_q.delete();
    for (int i = 0; i < 8; i++) send_word(8'h10 + 8'(i));
    cycles(2);
    chk_seq("rr_all", '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3});
    chk("rr_all_sent", 32'(sent_cnt), 32'd8);

    // Round-robin with channels 1 and 3 only.
    cfg_en = 4'b1010;
    del_q.delete();
    for (int i = 0; i < 4; i++) send_word(8'h20 + 8'(i));
    cycles(2);
    chk_seq("rr_1010", '{2'd1, 2'd3, 2'd1, 2'd3});
    chk("rr_1010_sent", 32'(sent_cnt), 32'd12);

    // Fixed channel 2 with three stalled cycles.
    cfg_mode = 1; cfg_fixed_sel = 2'd2; cfg_en = 4'hF; out_ready = 4'h0;
    del_q.delete();
    ov_cnt = 0;
    send_word(8'hA5);
    cycles(3);
    out_ready = 4'b0100;
    cycles(1);
    out_ready = 4'h0;
    cycles(2);
    chk("fixed_valid_cycles", 32'(ov_cnt), 32'd4);
    chk("fixed_sent", 32'(sent_cnt), 32'd13);
    chk_seq("fixed", '{2'd2});

    // Timeout drop.
    cfg_mode = 0; cfg_en = 4'hF; out_ready = 4'h0;
    ov_cnt = 0; drop_cnt = 0;
    send_word(8'hC3);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (drop_pulse) begin
        seen = 1;
        chk("to_in_ready", 32'(in_ready), 32'd1);
      end
    end
    chk("to_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    cycles(3);
    chk("to_valid_cycles", 32'(ov_cnt), 32'd15);
    chk("to_drops", 32'(drop_cnt), 32'd1);
    chk("to_sent", 32'(sent_cnt), 32'd13);

    // Enable removed mid-SEND: word on channel 0 is dropped.
    drop_cnt = 0;
    send_word(8'h55);
    cfg_en = 4'b1110;
    cycles(3);
    chk("en_drop", 32'(drop_cnt), 32'd1);
    chk("en_drop_sent", 32'(sent_cnt), 32'd13);
    out_ready = 4'hF;
    del_q.delete();
    send_word(8'h66);
    cycles(2);
    chk_seq("after_drop", '{2'd1});
    chk("after_drop_sent", 32'(sent_cnt), 32'd14);

    // Enable removed in the same cycle the channel accepts: delivered.
    out_ready = 4'h0;
    del_q.delete();
    send_word(8'h77);
    cycles(1);
    cfg_en = 4'b1010; out_ready = 4'b0100;
    cycles(1);
    out_ready = 4'h0;
    cycles(2);
    chk("race_drops", 32'(drop_cnt), 32'd1);
    chk("race_sent", 32'(sent_cnt), 32'd15);
    chk_seq("race", '{2'd2});

    // Reset in the middle of SEND.
    cfg_en = 4'hF; out_ready = 4'h0; drop_cnt = 0;
    send_word(8'h99);
    cycles(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_sent", 32'(sent_cnt), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    cfg_en = 4'h0; in_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("noen_in_ready", 32'(in_ready), 32'd0);
      chk("noen_out_valid", 32'(out_valid), 32'd0);
    end
    chk("mid_rst_no_drop", 32'(drop_cnt), 32'd0);
    @(posedge clk); #1;

    // Randomized traffic against the model.
    cfg_en = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      case ((i / 250) % 4)
        0: p = 0;
        1: p = 30;
        2: p = 70;
        default: p = 100;
      endcase
      for (int b = 0; b < 4; b++) out_ready[b] = ($urandom_range(99) < p);
      in_valid = ($urandom_range(3) != 0);
      in_data  = DATA_W'($urandom);
      if ($urandom_range(15) == 0) cfg_en = 4'($urandom);
      if ($urandom_range(31) == 0) cfg_mode = ~cfg_mode;
      if ($urandom_range(7) == 0) cfg_fixed_sel = 2'($urandom);
      rst_n = (i != 1700);
      cycles(1);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
